// File: rtl/kyber_pmul_seq_if.sv
`default_nettype none
// ============================================================================
// kyber_pmul_seq_if : host stream and HPM control bundle for kyber_pmul_seq
// Revision: 1.0
// ============================================================================
interface kyber_pmul_seq_if;
  logic        start;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic [7:0]  out_idx;
  logic        busy;
  logic        job_done;
  logic        error;
  logic        hpm_load_a_f;
  logic        hpm_load_b_f;
  logic        hpm_read_a;
  logic        hpm_start_ab;
  logic        hpm_start_fntt;
  logic        hpm_start_pwm2;
  logic        hpm_start_intt;
  logic [11:0] hpm_din;
  logic [11:0] hpm_dout;
  logic        hpm_done;

  // Sequencer side
  modport slave (
    input  start, in_valid, in_data, hpm_dout, hpm_done,
    output in_ready, out_valid, out_data, out_idx, busy, job_done, error,
           hpm_load_a_f, hpm_load_b_f, hpm_read_a, hpm_start_ab,
           hpm_start_fntt, hpm_start_pwm2, hpm_start_intt, hpm_din
  );

  // Host / HPM side
  modport master (
    output start, in_valid, in_data, hpm_dout, hpm_done,
    input  in_ready, out_valid, out_data, out_idx, busy, job_done, error,
           hpm_load_a_f, hpm_load_b_f, hpm_read_a, hpm_start_ab,
           hpm_start_fntt, hpm_start_pwm2, hpm_start_intt, hpm_din
  );
endinterface
`default_nettype wire

// File: rtl/kyber_pmul_seq.sv
`default_nettype none
// ============================================================================
// kyber_pmul_seq : sequences one polynomial multiply on the HPM core
//   (load A, load B, FNTT x2, PWM2, INTT, read out). Option: KYBER_SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module kyber_pmul_seq #(
  parameter int TMO = 4095
) (
  input  logic            clk,
  input  logic            reset,
  kyber_pmul_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LDA_WAIT, S_LDA_PULSE, S_LDA_DATA, S_LDB_WAIT, S_LDB_PULSE,
    S_LDB_DATA, S_OP_PULSE, S_OP_HOLD, S_OP_WAIT, S_RD_PULSE, S_RD_HOLD,
    S_RD_DATA, S_FIN, S_ERR
  } state_t;

  if (TMO < 1) begin : g_tmo_range
    $error("kyber_pmul_seq: TMO must be at least 1");
  end

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        error_q, error_d;
  logic [11:0] hpm_din_q, hpm_din_d;

`ifdef KYBER_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      error_q   <= 1'b0;
      hpm_din_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      error_q   <= error_d;
      hpm_din_q <= hpm_din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    error_d   = error_q;
    hpm_din_d = hpm_din_q;
`ifdef KYBER_SEQ_TIMEOUT_EN
    tmo_cnt_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LDA_WAIT;
          error_d = 1'b0;
          cnt_d   = '0;
          op_d    = '0;
        end
      end
      // The first word is only peeked here; it is consumed in the data phase.
      S_LDA_WAIT:  if (bus.in_valid) state_d = S_LDA_PULSE;
      S_LDB_WAIT:  if (bus.in_valid) state_d = S_LDB_PULSE;
      S_LDA_PULSE: begin state_d = S_LDA_DATA; cnt_d = '0; end
      S_LDB_PULSE: begin state_d = S_LDB_DATA; cnt_d = '0; end
      S_LDA_DATA, S_LDB_DATA: begin
        if (!bus.in_valid) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          hpm_din_d = bus.in_data;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'd255)
            state_d = (state_q == S_LDA_DATA) ? S_LDB_WAIT : S_OP_PULSE;
        end
      end
      S_OP_PULSE: begin state_d = S_OP_HOLD; cnt_d = '0; end
      // hpm_done may still reflect the previous op during the hold window.
      S_OP_HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd1) state_d = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        if (bus.hpm_done) begin
          if (op_q == 3'd3) begin
            state_d = S_RD_PULSE;
          end else begin
            op_d    = op_q + 3'd1;
            state_d = S_OP_PULSE;
          end
        end
`ifdef KYBER_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      S_RD_PULSE: begin state_d = S_RD_HOLD; cnt_d = '0; end
      S_RD_HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RD_DATA;
          cnt_d   = '0;
        end
      end
      S_RD_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic load_a, load_b, read_a, start_ab, start_fntt, start_pwm2, start_intt;
  logic rd_active;

  always_comb begin
    load_a     = 1'b0;
    load_b     = 1'b0;
    read_a     = 1'b0;
    start_ab   = 1'b0;
    start_fntt = 1'b0;
    start_pwm2 = 1'b0;
    start_intt = 1'b0;
    case (state_q)
      S_LDA_PULSE: load_a = 1'b1;
      S_LDB_PULSE: load_b = 1'b1;
      S_RD_PULSE:  read_a = 1'b1;
      S_OP_PULSE: begin
        case (op_q)
          3'd0:    start_fntt = 1'b1;
          3'd1:    begin start_fntt = 1'b1; start_ab = 1'b1; end
          3'd2:    start_pwm2 = 1'b1;
          3'd3:    start_intt = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Readout interleaves halves: word n lands at index {n[0], n[7:1]}.
  assign rd_active          = (state_q == S_RD_DATA);
  assign bus.out_valid      = rd_active;
  assign bus.out_data       = rd_active ? bus.hpm_dout : 12'd0;
  assign bus.out_idx        = rd_active ? {cnt_q[0], cnt_q[7:1]} : 8'd0;
  assign bus.in_ready       = (state_q == S_LDA_DATA) || (state_q == S_LDB_DATA);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.job_done       = (state_q == S_FIN);
  assign bus.error          = error_q;
  assign bus.hpm_din        = hpm_din_q;
  assign bus.hpm_load_a_f   = load_a;
  assign bus.hpm_load_b_f   = load_b;
  assign bus.hpm_read_a     = read_a;
  assign bus.hpm_start_ab   = start_ab;
  assign bus.hpm_start_fntt = start_fntt;
  assign bus.hpm_start_pwm2 = start_pwm2;
  assign bus.hpm_start_intt = start_intt;

endmodule
`default_nettype wire

// File: tb/tb_kyber_pmul_seq.sv
`default_nettype none
// ============================================================================
// tb_kyber_pmul_seq : directed self-checking bench for kyber_pmul_seq
// Revision: 1.0
// ============================================================================
module tb_kyber_pmul_seq;
  localparam int TB_TMO  = 10;
  localparam int HPM_LAT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kyber_pmul_seq_if ifc ();
  kyber_pmul_seq #(.TMO(TB_TMO)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic force_done = 1'b0;
  bit   hpm_auto = 1'b0;
  int   dtmr = 0;
  bit   darm = 1'b0;
  int   slog[$];
  int   n_overlap = 0;
  int   jd_cnt = 0;

  // HPM stand-in: done pulses HPM_LAT cycles after the strobe clears.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ifc.hpm_start_fntt || ifc.hpm_start_pwm2 || ifc.hpm_start_intt) begin
      darm <= hpm_auto;
      dtmr <= HPM_LAT;
    end else if (darm) begin
      if (dtmr == 0) darm <= 1'b0;
      else           dtmr <= dtmr - 1;
    end
  end
  assign ifc.hpm_dout = cyc[11:0];
  assign ifc.hpm_done = force_done | (darm && dtmr == 0);

  always @(negedge clk) begin
    if ($countones({ifc.hpm_load_a_f, ifc.hpm_load_b_f, ifc.hpm_read_a,
                    ifc.hpm_start_fntt, ifc.hpm_start_pwm2, ifc.hpm_start_intt}) > 1)
      n_overlap <= n_overlap + 1;
    if (ifc.hpm_load_a_f)   slog.push_back(1);
    if (ifc.hpm_load_b_f)   slog.push_back(2);
    if (ifc.hpm_start_fntt) slog.push_back(ifc.hpm_start_ab ? 4 : 3);
    if (ifc.hpm_start_pwm2) slog.push_back(ifc.hpm_start_ab ? 9 : 5);
    if (ifc.hpm_start_intt) slog.push_back(ifc.hpm_start_ab ? 9 : 6);
    if (ifc.hpm_read_a)     slog.push_back(7);
    if (ifc.job_done)       jd_cnt <= jd_cnt + 1;
  end

  function automatic logic [11:0] word_a(int i);
    return 12'(i * 13 + 1);
  endfunction
  function automatic logic [11:0] word_b(int i);
    return 12'(4000 - i * 11);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.start = 1'b0; ifc.in_valid = 1'b0; force_done = 1'b0; hpm_auto = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  // Start a job and stream 512 valid words; returns in OP_PULSE of FNTT(0).
  task automatic drive_load();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      ifc.in_valid = 1'b1; tick(); tick();
      for (int i = 0; i < 256; i++) begin
        ifc.in_data = (ph == 0) ? word_a(i) : word_b(i);
        tick();
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  // From an OP_PULSE cycle, let the op finish; returns in the next pulse state.
  task automatic run_op();
    tick(); tick(); tick();
    force_done = 1'b1; tick(); force_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] ctl;
    ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = 12'h0;
    reset = 1'b1;
    tick(); tick();
    ctl = {ifc.busy, ifc.in_ready, ifc.out_valid, ifc.job_done, ifc.error,
           ifc.hpm_load_a_f, ifc.hpm_load_b_f, ifc.hpm_read_a, ifc.hpm_start_ab,
           ifc.hpm_start_fntt, ifc.hpm_start_pwm2, ifc.hpm_start_intt, ifc.out_idx};
    n_cmp++; if (ctl !== 20'h0) begin n_bad++; $display("FAIL reset_ctl: got %h want 0", ctl); end
    n_cmp++; if (ifc.out_data !== 12'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", ifc.out_data); end
    n_cmp++; if (ifc.hpm_din !== 12'h0) begin n_bad++; $display("FAIL reset_hpm_din: got %h want 0", ifc.hpm_din); end
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", ifc.busy); end
  endtask

  task automatic test_full_job();
    int bad_din, bad_rdy, bad_ov, bad_idx, bad_od, waitc, jd0, base, bad_log;
    int exp_log[7];
    logic [11:0] w;
    logic [7:0]  exp_idx;
    exp_log = '{1, 2, 3, 4, 5, 6, 7};
    base = slog.size(); jd0 = jd_cnt; hpm_auto = 1'b1;
    bad_din = 0; bad_rdy = 0; bad_ov = 0; bad_idx = 0; bad_od = 0;
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL job_busy: got %b want 1", ifc.busy); end
    ifc.in_valid = 1'b1; ifc.in_data = word_a(0);
    tick();
    n_cmp++; if (ifc.hpm_load_a_f !== 1'b1 || ifc.in_ready !== 1'b0) begin n_bad++;
      $display("FAIL load_a_pulse: got load_a=%b in_ready=%b want 1/0", ifc.hpm_load_a_f, ifc.in_ready); end
    n_cmp++; if (ifc.hpm_din !== 12'h0) begin n_bad++; $display("FAIL wait_not_consumed: got %h want 0", ifc.hpm_din); end
    tick();
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        tick();
        n_cmp++; if (ifc.hpm_load_b_f !== 1'b1) begin n_bad++; $display("FAIL load_b_pulse: got %b want 1", ifc.hpm_load_b_f); end
        tick();
      end
      for (int i = 0; i < 256; i++) begin
        w = (ph == 0) ? word_a(i) : word_b(i);
        ifc.in_data = w;
        if (ifc.in_ready !== 1'b1) bad_rdy++;
        tick();
        if (ifc.hpm_din !== w) bad_din++;
      end
    end
    ifc.in_valid = 1'b0;
    n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL load_in_ready: got %0d low cycles want 0", bad_rdy); end
    n_cmp++; if (bad_din != 0) begin n_bad++; $display("FAIL load_hpm_din: got %0d bad words want 0", bad_din); end
    waitc = 0;
    while (ifc.hpm_read_a !== 1'b1 && waitc < 300) begin tick(); waitc++; end
    n_cmp++; if (waitc != 28) begin n_bad++; $display("FAIL ops_latency: got %0d cycles to read_a want 28", waitc); end
    tick(); tick(); tick();
    for (int k = 0; k < 256; k++) begin
      exp_idx = (k % 2 == 0) ? 8'(k / 2) : 8'(128 + k / 2);
      if (ifc.out_valid !== 1'b1) bad_ov++;
      if (ifc.out_idx !== exp_idx) bad_idx++;
      if (ifc.out_data !== cyc[11:0]) bad_od++;
      tick();
    end
    n_cmp++; if (bad_ov != 0) begin n_bad++; $display("FAIL rd_out_valid: got %0d low cycles want 0", bad_ov); end
    n_cmp++; if (bad_idx != 0) begin n_bad++; $display("FAIL rd_out_idx: got %0d bad indices want 0", bad_idx); end
    n_cmp++; if (bad_od != 0) begin n_bad++; $display("FAIL rd_out_data: got %0d bad words want 0", bad_od); end
    n_cmp++; if (ifc.job_done !== 1'b1 || ifc.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL fin_state: got job_done=%b out_valid=%b want 1/0", ifc.job_done, ifc.out_valid); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0 || ifc.job_done !== 1'b0) begin n_bad++;
      $display("FAIL job_idle: got busy=%b job_done=%b want 0/0", ifc.busy, ifc.job_done); end
    n_cmp++; if (jd_cnt - jd0 != 1) begin n_bad++; $display("FAIL job_done_count: got %0d want 1", jd_cnt - jd0); end
    n_cmp++; if (ifc.error !== 1'b0) begin n_bad++; $display("FAIL job_error: got %b want 0", ifc.error); end
    bad_log = 0;
    if (slog.size() != base + 7) bad_log = 99;
    else for (int j = 0; j < 7; j++) if (slog[base + j] != exp_log[j]) bad_log++;
    n_cmp++; if (bad_log != 0) begin n_bad++;
      $display("FAIL strobe_order: got %0d wrong (log len %0d) want 0", bad_log, slog.size() - base); end
    n_cmp++; if (n_overlap != 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", n_overlap); end
    hpm_auto = 1'b0;
  endtask

  task automatic test_abort();
    int base;
    base = slog.size();
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    ifc.in_valid = 1'b1; tick(); tick();
    for (int i = 0; i < 100; i++) begin ifc.in_data = word_a(i); tick(); end
    ifc.in_valid = 1'b0;
    tick();
    n_cmp++; if (ifc.error !== 1'b1 || ifc.busy !== 1'b1) begin n_bad++;
      $display("FAIL abort_err: got error=%b busy=%b want 1/1", ifc.error, ifc.busy); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0 || ifc.error !== 1'b1) begin n_bad++;
      $display("FAIL abort_idle: got busy=%b error=%b want 0/1", ifc.busy, ifc.error); end
    tick(); tick();
    n_cmp++; if (ifc.error !== 1'b1) begin n_bad++; $display("FAIL abort_sticky: got %b want 1", ifc.error); end
    n_cmp++; if (slog.size() != base + 1) begin n_bad++;
      $display("FAIL abort_strobes: got %0d strobes want 1 (load_a only)", slog.size() - base); end
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    n_cmp++; if (ifc.error !== 1'b0 || ifc.busy !== 1'b1) begin n_bad++;
      $display("FAIL restart_clear: got error=%b busy=%b want 0/1", ifc.error, ifc.busy); end
    do_reset();
  endtask

  task automatic test_done_in_hold();
    logic [2:0] st;
    drive_load();
    n_cmp++; if (ifc.hpm_start_fntt !== 1'b1 || ifc.hpm_start_ab !== 1'b0) begin n_bad++;
      $display("FAIL fntt0_pulse: got fntt=%b ab=%b want 1/0", ifc.hpm_start_fntt, ifc.hpm_start_ab); end
    force_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 2) force_done = 1'b0;
      st = {ifc.hpm_start_fntt, ifc.hpm_start_pwm2, ifc.hpm_start_intt};
      n_cmp++; if (st !== 3'b000) begin n_bad++; $display("FAIL hold_ignore_done c%0d: got strobes %b want 000", c, st); end
    end
    tick(); tick();
    n_cmp++; if (ifc.hpm_start_fntt !== 1'b0 || ifc.busy !== 1'b1) begin n_bad++;
      $display("FAIL wait_no_done: got fntt=%b busy=%b want 0/1", ifc.hpm_start_fntt, ifc.busy); end
    force_done = 1'b1; tick(); force_done = 1'b0;
    n_cmp++; if (ifc.hpm_start_fntt !== 1'b1 || ifc.hpm_start_ab !== 1'b1) begin n_bad++;
      $display("FAIL fntt1_pulse: got fntt=%b ab=%b want 1/1", ifc.hpm_start_fntt, ifc.hpm_start_ab); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int jd0;
    logic [19:0] ctl;
    jd0 = jd_cnt;
    drive_load(); run_op(); run_op();
    n_cmp++; if (ifc.hpm_start_pwm2 !== 1'b1) begin n_bad++; $display("FAIL pwm2_pulse: got %b want 1", ifc.hpm_start_pwm2); end
    tick(); tick(); tick(); tick();
    #3 reset = 1'b1;
    #1;
    ctl = {ifc.busy, ifc.in_ready, ifc.out_valid, ifc.job_done, ifc.error,
           ifc.hpm_load_a_f, ifc.hpm_load_b_f, ifc.hpm_read_a, ifc.hpm_start_ab,
           ifc.hpm_start_fntt, ifc.hpm_start_pwm2, ifc.hpm_start_intt, ifc.out_idx};
    n_cmp++; if (ctl !== 20'h0) begin n_bad++; $display("FAIL midrst_ctl: got %h want 0", ctl); end
    n_cmp++; if (ifc.hpm_din !== 12'h0 || ifc.out_data !== 12'h0) begin n_bad++;
      $display("FAIL midrst_data: got din=%h out=%h want 0/0", ifc.hpm_din, ifc.out_data); end
    tick(); reset = 1'b0;
    ifc.start = 1'b1; tick(); ifc.start = 1'b0;
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_restart: got busy=%b want 1", ifc.busy); end
    n_cmp++; if (jd_cnt != jd0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", jd_cnt - jd0); end
    do_reset();
  endtask

`ifdef KYBER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    drive_load();
    tick(); tick(); tick();
    for (int w = 0; w < TB_TMO; w++) begin
      if (ifc.error !== 1'b0) early++;
      tick();
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL tmo_early: got %0d early errors want 0", early); end
    n_cmp++; if (ifc.error !== 1'b1) begin n_bad++; $display("FAIL tmo_error: got %b want 1", ifc.error); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got busy=%b want 0", ifc.busy); end
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_full_job();
    test_abort();
    test_done_in_hold();
    test_reset_mid();
`ifdef KYBER_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
